receiver_uart: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the SoC's transmit UART.
- Sits on the SoC's memory-mapped IO bus: the RX pin enters here, and the received byte and status feed the IO read mux.
- Provides a single-byte holding register with a valid flag, plus sticky framing-error and overrun flags.
- The CPU pops the byte with a one-cycle read strobe.

---
 rtl/receiver_uart.sv | 163 ++++++++++++++++
 tb/tb_receiver_uart.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/receiver_uart.sv
`timescale 1ns/1ps
// receiver_uart: 8N1 UART receiver with a single-byte holding register,
// a valid flag and sticky framing-error / overrun flags for the IO bus.
//
// Handshake: a byte is offered while o_valid=1; the CPU takes it by pulsing
// i_rd for one cycle, which clears o_valid on the next edge. A commit in the
// same cycle as i_rd replaces the byte instead of being dropped. i_rd while
// o_valid=0 has no effect.
module receiver_uart #(
  parameter int clk_freq_hz = 12000000,
  parameter int baud_rate   = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_rx,
  input  logic       i_rd,
  input  logic       i_clr,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic [2:0] o_dbg_state
);

  localparam int DIV  = clk_freq_hz / baud_rate;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  // Too few clocks per bit leaves no room for mid-bit sampling.
  if (DIV < 4) begin : g_div_check
    $error("receiver_uart: clk_freq_hz / baud_rate must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          cnt_done;
  logic          commit;
  logic          frame_bad;

  assign cnt_done = (cnt_q == CNT_LAST);

  // All flops: two-stage line synchronizer, FSM, counters and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next state of the frame FSM plus its bit timer, bit index and shifter.
  always_comb begin
    rx_meta_d = i_rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Re-check the line half a bit in so glitches are rejected.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_done) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line (break) must not be decoded as a string of bytes.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register and sticky flags; a new error event beats i_clr.
  always_comb begin
    commit      = (state_q == S_STOP) && cnt_done && rx_s_q;
    frame_bad   = (state_q == S_STOP) && cnt_done && !rx_s_q;
    data_d      = data_q;
    valid_d     = valid_q & ~i_rd;
    frame_err_d = frame_err_q & ~i_clr;
    overrun_d   = overrun_q & ~i_clr;
    if (commit) begin
      if (!valid_q || i_rd) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (frame_bad) frame_err_d = 1'b1;
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_receiver_uart.sv
`timescale 1ns/1ps
// tb_receiver_uart: directed corner sequences, a vector table and randomized
// frames checked against a frame-level model of the receiver.
module tb_receiver_uart;

  localparam int CLK_HZ = 12000000;
  localparam int BAUD   = 115200;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int HALF   = DIV / 2;
  // Pin fall to commit edge: 3 edges to reach E0, then HALF + 9*DIV.
  localparam int COMMIT_LAT = 3 + HALF + 9 * DIV;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b1;
  logic       i_rx  = 1'b1;
  logic       i_rd  = 1'b0;
  logic       i_clr = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic [2:0] o_dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       do_rd;
    logic       do_clr;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[6];

  receiver_uart #(.clk_freq_hz(CLK_HZ), .baud_rate(BAUD)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_rx       (i_rx),
    .i_rd       (i_rd),
    .i_clr      (i_clr),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_dbg_state(o_dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Time limit
  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] d, input logic v,
                            input logic fe, input logic ov);
    check({tag, ".data"},  32'(o_data),      32'(d));
    check({tag, ".valid"}, 32'(o_valid),     32'(v));
    check({tag, ".fe"},    32'(o_frame_err), 32'(fe));
    check({tag, ".ov"},    32'(o_overrun),   32'(ov));
  endtask

  // Drivers: all start and end on a falling clock edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
    i_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      repeat (DIV) @(negedge clk);
    end
    i_rx = stop;
    repeat (DIV) @(negedge clk);
    i_rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_rd();
    i_rd = 1'b1;
    @(negedge clk);
    i_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    i_clr = 1'b1;
    @(negedge clk);
    i_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] m_data;
    logic       m_valid, m_fe, m_ov;
    logic [7:0] b;
    logic       stop;

    vecs[0] = '{8'h81, 1'b1, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h7E, 1'b1, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};

    // Reset
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset.state", 32'(o_dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5: exact commit latency, then pop
    fork
      send_frame(8'hA5, 1'b1, 8);
      begin
        repeat (COMMIT_LAT - 1) @(posedge clk);
        #1 check("lat.before", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1 check("lat.valid", 32'(o_valid), 32'd1);
        check("lat.data", 32'(o_data), 32'hA5);
      end
    join
    pulse_rd();
    check_outs("a5.pop", 8'hA5, 1'b0, 1'b0, 1'b0);

    // False start: 20-clock low pulse
    i_rx = 1'b0;
    fork
      begin
        repeat (20) @(negedge clk);
        i_rx = 1'b1;
      end
      begin
        repeat (3 + HALF - 1) @(posedge clk);
        #1 check("glitch.start", 32'(o_dbg_state), 32'(ST_START));
        @(posedge clk);
        #1 check("glitch.idle", 32'(o_dbg_state), 32'(ST_IDLE));
      end
    join
    repeat (1100) @(negedge clk);
    check_outs("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Framing error followed by a 300-clock break, then a clean frame
    send_frame(8'h3C, 1'b0, 0);
    i_rx = 1'b0;
    repeat (300) @(negedge clk);
    check_outs("ferr", 8'hA5, 1'b0, 1'b1, 1'b0);
    i_rx = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b1, 8);
    check_outs("after_break", 8'h5A, 1'b1, 1'b1, 1'b0);
    pulse_clr();
    check_outs("ferr.clr", 8'h5A, 1'b1, 1'b0, 1'b0);
    pulse_rd();

    // Back-to-back frames without a read
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 8);
    check_outs("overrun", 8'h11, 1'b1, 1'b0, 1'b1);
    pulse_rd();
    check("overrun.rd", 32'(o_valid), 32'd0);
    pulse_clr();
    check("overrun.clr", 32'(o_overrun), 32'd0);

    // Read strobe exactly on the commit edge replaces the held byte
    send_frame(8'h11, 1'b1, 8);
    check_outs("held11", 8'h11, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 8);
      begin
        repeat (COMMIT_LAT - 1) @(posedge clk);
        @(negedge clk);
        i_rd = 1'b1;
        @(negedge clk);
        i_rd = 1'b0;
      end
    join
    check_outs("rd_on_commit", 8'h22, 1'b1, 1'b0, 1'b0);
    send_frame(8'h33, 1'b1, 8);
    check_outs("pre_reset_ov", 8'h22, 1'b1, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 16);
    check_outs("pre_reset_fe", 8'h22, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of frame 0x77; released while the stop bit is high
    fork
      send_frame(8'h77, 1'b1, 16);
      begin
        repeat (400) @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_outs("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("midreset.state", 32'(o_dbg_state), 32'(ST_IDLE));
        repeat (550) @(negedge clk);
        rstn = 1'b1;
      end
    join
    check_outs("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h42, 1'b1, 8);
    check_outs("after_reset", 8'h42, 1'b1, 1'b0, 1'b0);
    pulse_rd();

    // Vector table
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, 12);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
                 vecs[i].exp_fe, vecs[i].exp_ov);
      if (vecs[i].do_rd) begin
        pulse_rd();
        check($sformatf("vec%0d.rd", i), 32'(o_valid), 32'd0);
      end
      if (vecs[i].do_clr) begin
        pulse_clr();
        check($sformatf("vec%0d.clr", i), 32'({o_frame_err, o_overrun}), 32'd0);
      end
    end

    // Randomized frames against a frame-level model
    m_data  = 8'h55;
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        if (m_valid) begin
          check($sformatf("rnd%0d.pop", n), 32'(o_data), 32'(exp_q.pop_front()));
          m_valid = 1'b0;
        end
        pulse_rd();
        check($sformatf("rnd%0d.rd", n), 32'(o_valid), 32'd0);
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_fe = 1'b0;
        m_ov = 1'b0;
      end
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, stop, $urandom_range(0, 40));
      if (!stop) begin
        m_fe = 1'b1;
      end else if (!m_valid) begin
        m_valid = 1'b1;
        m_data  = b;
        exp_q.push_back(b);
      end else begin
        m_ov = 1'b1;
      end
      check_outs($sformatf("rnd%0d", n), m_data, m_valid, m_fe, m_ov);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
